// File: rtl/cmsdk_apb_slave_mux_tmo.sv
// APB slave multiplexer: fans PSEL out to one of up to 16 slaves and muxes the response back, with an access-phase watchdog.
// Latency: response path is combinational; a stalled access is force-completed with an error in access cycle TIMEOUT_CYCLES+1.
// Backpressure: upstream PREADY follows the selected slave's PREADYS; unmapped ports and watchdog expiry complete at once.
module cmsdk_apb_slave_mux_tmo #(
  parameter int          NUM_PORTS      = 16,
  parameter logic [15:0] PORT_EN_MASK   = 16'hFFFF,
  parameter int          DATA_W         = 32,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter bit          UNMAPPED_ERR   = 1'b1
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic [3:0]                  DECODE4BIT,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic [NUM_PORTS-1:0]        PSELS,
  input  logic [NUM_PORTS-1:0]        PREADYS,
  input  logic [NUM_PORTS*DATA_W-1:0] PRDATAS,
  input  logic [NUM_PORTS-1:0]        PSLVERRS,
  output logic                        PREADY,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PSLVERR,
  input  logic                        TMO_CLR,
  output logic                        TMO_FLAG,
  output logic [3:0]                  TMO_PORT
);

  localparam logic [4:0] NUM_PORTS_W = 5'(NUM_PORTS);
  localparam logic [4:0] TMO_LIM     = 5'(TIMEOUT_CYCLES);
  // The IDLE cycle is access cycle 1, so the ACCESS-state count reaching
  // TIMEOUT_CYCLES-1 marks access cycle TIMEOUT_CYCLES: leave for TMO then.
  localparam logic [4:0] TMO_LAST    = (TIMEOUT_CYCLES > 0) ? 5'(TIMEOUT_CYCLES - 1) : 5'd0;
  localparam bit         WDOG_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TMO    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        cnt;
  logic [4:0]        cnt_inc;
  logic [3:0]        cap_port;
  logic              mapped;
  logic              sel_rdy;
  logic              sel_err;
  logic [DATA_W-1:0] sel_dat;

  assign mapped  = ({1'b0, DECODE4BIT} < NUM_PORTS_W) && PORT_EN_MASK[DECODE4BIT];
  // Saturating count including the current wait cycle.
  assign cnt_inc = (cnt == TMO_LIM) ? cnt : cnt + 5'd1;

  // Pick the addressed slave's response; unmapped indices read as all-zero.
  always_comb begin
    sel_rdy = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mapped && (DECODE4BIT == 4'(i))) begin
        sel_rdy = PREADYS[i];
        sel_err = PSLVERRS[i];
        sel_dat = PRDATAS[i*DATA_W +: DATA_W];
      end
    end
  end

  // Per-port select fan-out, suppressed while the watchdog completes a transfer.
  always_comb begin
    PSELS = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((state != ST_TMO) && mapped && (DECODE4BIT == 4'(i))) begin
        PSELS[i] = PSEL;
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arm on a stalled access phase, disarm on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (WDOG_EN && PSEL && PENABLE && mapped && !sel_rdy) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || sel_rdy) begin
          state_nxt = ST_IDLE;
        end else if (cnt_inc >= TMO_LAST) begin
          state_nxt = ST_TMO;
        end
      end
      ST_TMO:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Upstream response: forced error completion in TMO, otherwise muxed slave response.
  always_comb begin
    if (state == ST_TMO) begin
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = '0;
    end else begin
      PREADY  = !PSEL || !PENABLE || !mapped || sel_rdy;
      PRDATA  = (PSEL && mapped) ? sel_dat : '0;
      if (PSEL && mapped) begin
        PSLVERR = sel_err;
      end else if (PSEL && PENABLE) begin
        PSLVERR = UNMAPPED_ERR;
      end else begin
        PSLVERR = 1'b0;
      end
    end
  end

  // Wait counter runs only while staying in ACCESS; port index latched on arming.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt      <= 5'd0;
      cap_port <= 4'd0;
    end else begin
      if ((state == ST_ACCESS) && (state_nxt == ST_ACCESS)) begin
        cnt <= cnt_inc;
      end else begin
        cnt <= 5'd0;
      end
      if ((state == ST_IDLE) && (state_nxt == ST_ACCESS)) begin
        cap_port <= DECODE4BIT;
      end
    end
  end

  // Sticky timeout status; a new timeout beats a simultaneous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      TMO_FLAG <= 1'b0;
      TMO_PORT <= 4'd0;
    end else if ((state_nxt == ST_TMO) && (state != ST_TMO)) begin
      TMO_FLAG <= 1'b1;
      TMO_PORT <= cap_port;
    end else if (TMO_CLR) begin
      TMO_FLAG <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmsdk_apb_slave_mux_tmo.sv
// Bench for cmsdk_apb_slave_mux_tmo: three instances (watchdog on / unmapped port 3 without watchdog / 8 ports).
// Latency: expectations are stamped with the cycle they apply to and checked at the following falling edge.
// Backpressure: stimulus only pushes expectations; a separate monitor pops and compares them.
module tb_cmsdk_apb_slave_mux_tmo;

  localparam int DW = 32;
  localparam int F_RDY = 0, F_ERR = 1, F_DAT = 2, F_SEL = 3, F_FLG = 4, F_PRT = 5;

  typedef struct {
    string       nm;
    int          dut;
    int          fld;
    logic [31:0] v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       dec;
  logic             psel, pen, tmo_clr;
  logic [15:0]      preadys, pslverrs;
  logic [16*DW-1:0] prdatas;

  logic [15:0] a_psels, b_psels;
  logic [7:0]  c_psels;
  logic        a_rdy, b_rdy, c_rdy, a_err, b_err, c_err, a_flg, b_flg, c_flg;
  logic [31:0] a_dat, b_dat, c_dat;
  logic [3:0]  a_prt, b_prt, c_prt;

  cmsdk_apb_slave_mux_tmo #(.NUM_PORTS(16), .PORT_EN_MASK(16'hFFFF), .DATA_W(DW),
                            .TIMEOUT_CYCLES(4), .UNMAPPED_ERR(1'b1)) u_a (
    .PCLK(clk), .PRESETn(rst_n), .DECODE4BIT(dec), .PSEL(psel), .PENABLE(pen),
    .PSELS(a_psels), .PREADYS(preadys), .PRDATAS(prdatas), .PSLVERRS(pslverrs),
    .PREADY(a_rdy), .PRDATA(a_dat), .PSLVERR(a_err), .TMO_CLR(tmo_clr),
    .TMO_FLAG(a_flg), .TMO_PORT(a_prt));

  cmsdk_apb_slave_mux_tmo #(.NUM_PORTS(16), .PORT_EN_MASK(16'hFFF7), .DATA_W(DW),
                            .TIMEOUT_CYCLES(0), .UNMAPPED_ERR(1'b1)) u_b (
    .PCLK(clk), .PRESETn(rst_n), .DECODE4BIT(dec), .PSEL(psel), .PENABLE(pen),
    .PSELS(b_psels), .PREADYS(preadys), .PRDATAS(prdatas), .PSLVERRS(pslverrs),
    .PREADY(b_rdy), .PRDATA(b_dat), .PSLVERR(b_err), .TMO_CLR(tmo_clr),
    .TMO_FLAG(b_flg), .TMO_PORT(b_prt));

  cmsdk_apb_slave_mux_tmo #(.NUM_PORTS(8), .PORT_EN_MASK(16'hFFFF), .DATA_W(DW),
                            .TIMEOUT_CYCLES(4), .UNMAPPED_ERR(1'b1)) u_c (
    .PCLK(clk), .PRESETn(rst_n), .DECODE4BIT(dec), .PSEL(psel), .PENABLE(pen),
    .PSELS(c_psels), .PREADYS(preadys[7:0]), .PRDATAS(prdatas[8*DW-1:0]), .PSLVERRS(pslverrs[7:0]),
    .PREADY(c_rdy), .PRDATA(c_dat), .PSLVERR(c_err), .TMO_CLR(tmo_clr),
    .TMO_FLAG(c_flg), .TMO_PORT(c_prt));

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_act(input int d, input int f);
    logic [31:0] r;
    r = '0;
    case (d)
      0: case (f)
           F_RDY: r = {31'd0, a_rdy};
           F_ERR: r = {31'd0, a_err};
           F_DAT: r = a_dat;
           F_SEL: r = {16'd0, a_psels};
           F_FLG: r = {31'd0, a_flg};
           default: r = {28'd0, a_prt};
         endcase
      1: case (f)
           F_RDY: r = {31'd0, b_rdy};
           F_ERR: r = {31'd0, b_err};
           F_DAT: r = b_dat;
           F_SEL: r = {16'd0, b_psels};
           F_FLG: r = {31'd0, b_flg};
           default: r = {28'd0, b_prt};
         endcase
      default: case (f)
           F_RDY: r = {31'd0, c_rdy};
           F_ERR: r = {31'd0, c_err};
           F_DAT: r = c_dat;
           F_SEL: r = {24'd0, c_psels};
           F_FLG: r = {31'd0, c_flg};
           default: r = {28'd0, c_prt};
         endcase
    endcase
    return r;
  endfunction

  // Monitor: compare every expectation due in this cycle, away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = get_act(e.dut, e.fld);
      checks++;
      if (e.cyc != cyc || act !== e.v) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.nm, e.cyc, act, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input int d, input int f, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.dut = d; e.fld = f; e.v = v; e.cyc = cyc;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; dec = 4'd0; psel = 1'b0; pen = 1'b0; tmo_clr = 1'b0;
    preadys = '1; pslverrs = '0;
    for (int n = 0; n < 16; n++) prdatas[n*DW +: DW] = 32'hA5A5_0000 | n;

    // Reset values
    tick;
    ex("rst_pready", 0, F_RDY, 1); ex("rst_flag", 0, F_FLG, 0);
    ex("rst_port", 0, F_PRT, 0);   ex("rst_psels", 0, F_SEL, 0);
    tick; rst_n = 1'b1;
    tick;

    // Port 3 ready after two wait cycles
    dec = 4'd3; psel = 1'b1; pen = 1'b0; preadys[3] = 1'b0;
    ex("s1_setup_sel", 0, F_SEL, 32'h8); ex("s1_setup_rdy", 0, F_RDY, 1);
    tick; pen = 1'b1; ex("s1_acc1_rdy", 0, F_RDY, 0);
    tick; ex("s1_acc2_rdy", 0, F_RDY, 0);
    tick; preadys[3] = 1'b1;
    ex("s1_acc3_rdy", 0, F_RDY, 1); ex("s1_acc3_dat", 0, F_DAT, 32'hA5A5_0003);
    ex("s1_acc3_err", 0, F_ERR, 0); ex("s1_acc3_flg", 0, F_FLG, 0);
    tick; psel = 1'b0; pen = 1'b0;
    ex("s1_idle_sel", 0, F_SEL, 0); ex("s1_idle_dat", 0, F_DAT, 0); ex("s1_idle_flg", 0, F_FLG, 0);

    // Port 5 never ready: watchdog on u_a, plain stall on u_b
    tick; dec = 4'd5; psel = 1'b1; pen = 1'b0; preadys[5] = 1'b0;
    ex("s2_setup_sel", 0, F_SEL, 32'h20);
    for (int k = 1; k <= 4; k++) begin
      tick; pen = 1'b1;
      ex($sformatf("s2_acc%0d_rdy", k), 0, F_RDY, 0);
      ex($sformatf("s2_acc%0d_sel", k), 0, F_SEL, 32'h20);
      ex($sformatf("s2_acc%0d_flg", k), 0, F_FLG, 0);
    end
    tick;
    ex("s2_tmo_rdy", 0, F_RDY, 1); ex("s2_tmo_err", 0, F_ERR, 1);
    ex("s2_tmo_dat", 0, F_DAT, 0); ex("s2_tmo_sel", 0, F_SEL, 0);
    ex("s2_nowd_rdy", 1, F_RDY, 0); ex("s2_nowd_sel", 1, F_SEL, 32'h20);
    tick; psel = 1'b0; pen = 1'b0; preadys[5] = 1'b1;
    ex("s2_after_flg", 0, F_FLG, 1); ex("s2_after_prt", 0, F_PRT, 5);
    ex("s2_nowd_flg", 1, F_FLG, 0);

    // Reset pulse in access cycle 3 of a stalled transfer on port 2
    tick; dec = 4'd2; psel = 1'b1; pen = 1'b0; preadys[2] = 1'b0;
    tick; pen = 1'b1; ex("s4_acc1_rdy", 0, F_RDY, 0);
    tick; ex("s4_acc2_rdy", 0, F_RDY, 0);
    tick; #1 rst_n = 1'b0;
    ex("s4_rst_flg", 0, F_FLG, 0); ex("s4_rst_prt", 0, F_PRT, 0);
    ex("s4_rst_rdy", 0, F_RDY, 0); ex("s4_rst_sel", 0, F_SEL, 32'h4);
    tick; psel = 1'b0; pen = 1'b0; preadys[2] = 1'b1;
    ex("s4_inrst_rdy", 0, F_RDY, 1); ex("s4_inrst_flg", 0, F_FLG, 0);
    tick; rst_n = 1'b1;
    tick; dec = 4'd4; psel = 1'b1; pen = 1'b0; preadys[4] = 1'b0;
    tick; pen = 1'b1; ex("s4_new_acc1_rdy", 0, F_RDY, 0);
    tick; preadys[4] = 1'b1;
    ex("s4_new_acc2_rdy", 0, F_RDY, 1); ex("s4_new_acc2_dat", 0, F_DAT, 32'hA5A5_0004);
    ex("s4_new_acc2_err", 0, F_ERR, 0);
    tick; psel = 1'b0; pen = 1'b0; ex("s4_new_flg", 0, F_FLG, 0);

    // Timeout on port 7 with TMO_CLR in the expiry cycle, then clear alone
    tick; dec = 4'd7; psel = 1'b1; pen = 1'b0; preadys[7] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick; pen = 1'b1; tmo_clr = (k == 4);
      ex($sformatf("s3_acc%0d_rdy", k), 0, F_RDY, 0);
    end
    tick; tmo_clr = 1'b0;
    ex("s3_tmo_rdy", 0, F_RDY, 1); ex("s3_tmo_err", 0, F_ERR, 1);
    tick; psel = 1'b0; pen = 1'b0; preadys[7] = 1'b1; tmo_clr = 1'b1;
    ex("s3_setwins_flg", 0, F_FLG, 1); ex("s3_setwins_prt", 0, F_PRT, 7);
    tick; tmo_clr = 1'b0;
    ex("s3_clr_flg", 0, F_FLG, 0); ex("s3_clr_prt", 0, F_PRT, 7);

    // Disabled port 3 on u_b; slave error passthrough on u_a
    tick; dec = 4'd3; psel = 1'b1; pen = 1'b0;
    ex("s5_setup_bsel", 1, F_SEL, 0); ex("s5_setup_brdy", 1, F_RDY, 1);
    ex("s5_setup_berr", 1, F_ERR, 0); ex("s5_setup_bdat", 1, F_DAT, 0);
    ex("s5_setup_asel", 0, F_SEL, 32'h8);
    tick; pen = 1'b1; pslverrs[3] = 1'b1;
    ex("s5_acc_bsel", 1, F_SEL, 0); ex("s5_acc_brdy", 1, F_RDY, 1); ex("s5_acc_berr", 1, F_ERR, 1);
    ex("s5_acc_aerr", 0, F_ERR, 1); ex("s5_acc_ardy", 0, F_RDY, 1);
    ex("s5_acc_adat", 0, F_DAT, 32'hA5A5_0003);
    tick; psel = 1'b0; pen = 1'b0; pslverrs = '0; dec = 4'd12;

    // Out-of-range port 12 on the 8-port instance
    tick; psel = 1'b1; pen = 1'b0;
    ex("s6_setup_csel", 2, F_SEL, 0); ex("s6_setup_asel", 0, F_SEL, 32'h1000);
    tick; pen = 1'b1;
    ex("s6_acc_csel", 2, F_SEL, 0); ex("s6_acc_crdy", 2, F_RDY, 1);
    ex("s6_acc_cerr", 2, F_ERR, 1); ex("s6_acc_cdat", 2, F_DAT, 0);
    tick; psel = 1'b0; pen = 1'b0;
    ex("s6_idle_berr", 1, F_ERR, 0); ex("s6_idle_cerr", 2, F_ERR, 0);

    tick; tick;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
